// File: rtl/store_buffer_if.sv
// Pipeline-side and memory-side bundle for store_buffer.
//   master : environment side (pipeline stage + Data_Memory model)
//   slave  : the store buffer itself
// Signals (direction seen from the store buffer):
//   addr_i, data_i, MemRead_i, MemWrite_i : pipeline request (in)
//   data_o, stall_o, count_o              : pipeline response (out)
//   mem_addr_o, mem_data_o,
//   mem_MemRead_o, mem_MemWrite_o         : to Data_Memory (out)
//   mem_data_i                            : from Data_Memory (in)
interface store_buffer_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] data_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [DATA_W-1:0] data_o;
  logic              stall_o;
  logic [CntW-1:0]   count_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic              mem_MemRead_o;
  logic              mem_MemWrite_o;
  logic [DATA_W-1:0] mem_data_i;

  modport master (
    output addr_i, data_i, MemRead_i, MemWrite_i, mem_data_i,
    input  data_o, stall_o, count_o, mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o
  );

  modport slave (
    input  addr_i, data_i, MemRead_i, MemWrite_i, mem_data_i,
    output data_o, stall_o, count_o, mem_addr_o, mem_data_o, mem_MemRead_o, mem_MemWrite_o
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer between the EX/MEM register and Data_Memory.
// Stores are absorbed into a circular FIFO in one cycle; buffered stores drain to memory in
// program order on cycles with no memory request (or while the pipeline is stalled). Loads go
// straight to memory, stalling while any buffered store partially overlaps the load address.
// Ports:
//   clk_i  : clock, all state on posedge
//   rst_i  : synchronous active-high reset, discards buffered stores
//   bus_io : store_buffer_if.slave, pipeline request/response and Data_Memory pins
// Build option:
//   STORE_BUFFER_FWD_EN : when defined, a load whose address exactly matches a buffered store
//   takes the youngest matching data. When undefined, an exact match stalls like a partial
//   overlap until the entry has drained, and the load then reads memory.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic            clk_i,
  input logic            rst_i,
  store_buffer_if.slave  bus_io
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic             is_load, is_store, full, hazard, stall, drain, enq, serve;
  logic [DEPTH-1:0] valid, overlap, match;

  // Distance of 1..3 bytes (either direction) means the two words share bytes but differ.
  function automatic logic near(input logic [ADDR_W-1:0] d);
    return (d != '0) && (d <= ADDR_W'(3));
  endfunction

  // Both strobes high is treated as a load; the store is dropped.
  assign is_load  = bus_io.MemRead_i;
  assign is_store = bus_io.MemWrite_i & ~bus_io.MemRead_i;
  assign full     = (count_q == CntW'(DEPTH));

  always_comb begin
    valid   = '0;
    overlap = '0;
    match   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from the head is below the fill level.
      valid[i]   = CntW'(PtrW'(i) - rd_ptr_q) < count_q;
      overlap[i] = valid[i] & (near(bus_io.addr_i - addr_q[i]) | near(addr_q[i] - bus_io.addr_i));
      match[i]   = valid[i] & (addr_q[i] == bus_io.addr_i);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;

  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    // Walk oldest to youngest so the last hit is the youngest store.
    for (int k = 0; k < DEPTH; k++) begin
      if (CntW'(k) < count_q && match[rd_ptr_q + PtrW'(k)]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[rd_ptr_q + PtrW'(k)];
      end
    end
  end

  assign hazard = |overlap;
`else
  assign hazard = |(overlap | match);
`endif

  assign stall = (is_load & hazard) | (is_store & full);
  assign serve = is_load & ~stall;
  assign enq   = is_store & ~full;
  assign drain = ((~is_load & ~is_store) | stall) & (count_q != '0);

  always_comb begin
    bus_io.stall_o        = stall;
    bus_io.count_o        = count_q;
    bus_io.data_o         = '0;
    bus_io.mem_addr_o     = '0;
    bus_io.mem_data_o     = '0;
    bus_io.mem_MemRead_o  = 1'b0;
    bus_io.mem_MemWrite_o = 1'b0;
    if (serve) begin
      bus_io.mem_MemRead_o = 1'b1;
      bus_io.mem_addr_o    = bus_io.addr_i;
`ifdef STORE_BUFFER_FWD_EN
      bus_io.data_o        = fwd_hit ? fwd_data : bus_io.mem_data_i;
`else
      bus_io.data_o        = bus_io.mem_data_i;
`endif
    end else if (drain) begin
      bus_io.mem_MemWrite_o = 1'b1;
      bus_io.mem_addr_o     = addr_q[rd_ptr_q];
      bus_io.mem_data_o     = data_q[rd_ptr_q];
    end
  end

  // Enqueue and drain never coincide: a store that enqueues is an unstalled request.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d  = count_q + CntW'(1);
    end else if (drain) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d  = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      addr_q[wr_ptr_q] <= bus_io.addr_i;
      data_q[wr_ptr_q] <= bus_io.data_i;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus ();

  store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  // Byte-addressed little-endian Data_Memory model, preset to a known pattern on reset.
  logic [7:0] mem [256];
  logic [7:0] maddr;
  assign maddr = bus.mem_addr_o[7:0];
  assign bus.mem_data_i = {mem[maddr + 8'd3], mem[maddr + 8'd2], mem[maddr + 8'd1], mem[maddr]};

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else if (bus.mem_MemWrite_o) begin
      for (int b = 0; b < 4; b++) mem[maddr + 8'(b)] <= bus.mem_data_o[8*b +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request, then at the falling edge compare any drain against the scoreboard.
  task automatic go(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    bus.MemRead_i  = rd;
    bus.MemWrite_i = wr;
    bus.addr_i     = a;
    bus.data_i     = d;
    @(negedge clk);
    if (bus.mem_MemWrite_o === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_drain", 32'(bus.mem_MemWrite_o), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("drain_addr", bus.mem_addr_o, e.a);
        chk("drain_data", bus.mem_data_o, e.d);
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    sb.push_back(e);
  endtask

  initial begin
    rst            = 1'b1;
    bus.MemRead_i  = 1'b0;
    bus.MemWrite_i = 1'b0;
    bus.addr_i     = '0;
    bus.data_i     = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state, idle and empty
    go(1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_data_o", bus.data_o, 32'd0);
    chk("rst_mem_rd", 32'(bus.mem_MemRead_o), 32'd0);
    chk("rst_mem_wr", 32'(bus.mem_MemWrite_o), 32'd0);
    chk("rst_mem_addr", bus.mem_addr_o, 32'd0);
    chk("rst_mem_data", bus.mem_data_o, 32'd0);
    adv();

    // 1: single store then drain on idle
    go(1'b0, 1'b1, 32'h10, 32'h11223344);
    push(32'h10, 32'h11223344);
    chk("t1_st_stall", 32'(bus.stall_o), 32'd0);
    chk("t1_st_nomem", 32'({bus.mem_MemRead_o, bus.mem_MemWrite_o}), 32'd0);
    adv();
    go(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_count1", 32'(bus.count_o), 32'd1);
    chk("t1_drain", 32'(bus.mem_MemWrite_o), 32'd1);
    adv();
    go(1'b0, 1'b0, 32'h0, 32'h0);
    chk("t1_count0", 32'(bus.count_o), 32'd0);
    chk("t1_mem", mem_word(8'h10), 32'h11223344);
    adv();

    // 2: two stores to one address, then a load of it
    go(1'b0, 1'b1, 32'h20, 32'd5);
    push(32'h20, 32'd5);
    adv();
    go(1'b0, 1'b1, 32'h20, 32'd7);
    push(32'h20, 32'd7);
    adv();
`ifdef STORE_BUFFER_FWD_EN
    go(1'b1, 1'b0, 32'h20, 32'h0);
    chk("t2_stall", 32'(bus.stall_o), 32'd0);
    chk("t2_fwd", bus.data_o, 32'd7);
    chk("t2_mem_rd", 32'(bus.mem_MemRead_o), 32'd1);
    chk("t2_count", 32'(bus.count_o), 32'd2);
    adv();
    for (int k = 0; k < 3; k++) begin
      go(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t2_count_idle", 32'(bus.count_o), 32'(2 - k));
      adv();
    end
`else
    for (int k = 0; k < 2; k++) begin
      go(1'b1, 1'b0, 32'h20, 32'h0);
      chk("t2_stall", 32'(bus.stall_o), 32'd1);
      chk("t2_data_stalled", bus.data_o, 32'd0);
      chk("t2_count", 32'(bus.count_o), 32'(2 - k));
      adv();
    end
    go(1'b1, 1'b0, 32'h20, 32'h0);
    chk("t2_unstall", 32'(bus.stall_o), 32'd0);
    chk("t2_load", bus.data_o, 32'd7);
    adv();
`endif
    chk("t2_mem", mem_word(8'h20), 32'd7);

    // 3: partial overlap stalls one cycle, then reads memory bytes 0x22..0x25
    go(1'b0, 1'b1, 32'h20, 32'hAABBCCDD);
    push(32'h20, 32'hAABBCCDD);
    adv();
    go(1'b1, 1'b0, 32'h22, 32'h0);
    chk("t3_stall", 32'(bus.stall_o), 32'd1);
    chk("t3_drain", 32'(bus.mem_MemWrite_o), 32'd1);
    chk("t3_data_stalled", bus.data_o, 32'd0);
    adv();
    go(1'b1, 1'b0, 32'h22, 32'h0);
    chk("t3_unstall", 32'(bus.stall_o), 32'd0);
    chk("t3_load", bus.data_o, 32'h7F7EAABB);
    adv();

    // 4: fill, stall a fifth store, then drain with pointer wrap
    for (int i = 0; i < 4; i++) begin
      go(1'b0, 1'b1, 32'(4 * i), 32'h100 + 32'(i));
      push(32'(4 * i), 32'h100 + 32'(i));
      chk("t4_fill_stall", 32'(bus.stall_o), 32'd0);
      adv();
    end
    go(1'b0, 1'b1, 32'h10, 32'h55);
    chk("t4_full_count", 32'(bus.count_o), 32'd4);
    chk("t4_full_stall", 32'(bus.stall_o), 32'd1);
    chk("t4_full_drain", 32'(bus.mem_MemWrite_o), 32'd1);
    adv();
    go(1'b0, 1'b1, 32'h10, 32'h55);
    push(32'h10, 32'h55);
    chk("t4_accept_stall", 32'(bus.stall_o), 32'd0);
    chk("t4_accept_count", 32'(bus.count_o), 32'd3);
    adv();
    for (int k = 0; k < 8; k++) begin
      go(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t4_idle_count", 32'(bus.count_o), (k < 4) ? 32'(4 - k) : 32'd0);
      adv();
    end
    chk("t4_mem_c", mem_word(8'h0C), 32'h103);
    chk("t4_mem_10", mem_word(8'h10), 32'h55);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: exact-match load
    go(1'b0, 1'b1, 32'h30, 32'd9);
    push(32'h30, 32'd9);
    adv();
`ifdef STORE_BUFFER_FWD_EN
    go(1'b1, 1'b0, 32'h30, 32'h0);
    chk("t5_stall", 32'(bus.stall_o), 32'd0);
    chk("t5_fwd", bus.data_o, 32'd9);
    adv();
    go(1'b0, 1'b0, 32'h0, 32'h0);
    adv();
`else
    go(1'b1, 1'b0, 32'h30, 32'h0);
    chk("t5_stall", 32'(bus.stall_o), 32'd1);
    chk("t5_drain", 32'(bus.mem_MemWrite_o), 32'd1);
    adv();
    go(1'b1, 1'b0, 32'h30, 32'h0);
    chk("t5_unstall", 32'(bus.stall_o), 32'd0);
    chk("t5_load", bus.data_o, 32'd9);
    adv();
`endif
    chk("t5_mem", mem_word(8'h30), 32'd9);

    // 6: reset with three buffered stores discards them
    for (int i = 0; i < 3; i++) begin
      go(1'b0, 1'b1, 32'h40 + 32'(4 * i), 32'hDEAD0000 + 32'(i));
      adv();
    end
    rst = 1'b1;
    go(1'b1, 1'b0, 32'h80, 32'h0);
    chk("t6_count3", 32'(bus.count_o), 32'd3);
    chk("t6_no_drain_rst", 32'(bus.mem_MemWrite_o), 32'd0);
    adv();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      go(1'b0, 1'b0, 32'h0, 32'h0);
      chk("t6_count0", 32'(bus.count_o), 32'd0);
      chk("t6_no_drain", 32'(bus.mem_MemWrite_o), 32'd0);
      adv();
    end

    chk("sb_final_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
